// File: rtl/lmul_uop_sequencer_pkg.sv
// Shared vector-group definitions: vlmul encodings, sequencer states, LMUL decode.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: VLMUL_* encodings, seq_state_t, lmul_decode() -> {lmul[3:0], illegal}.
package vec_pkg;

    localparam logic [2:0] VLMUL_M1   = 3'b000;
    localparam logic [2:0] VLMUL_M2   = 3'b001;
    localparam logic [2:0] VLMUL_M4   = 3'b010;
    localparam logic [2:0] VLMUL_M8   = 3'b011;
    localparam logic [2:0] VLMUL_RSVD = 3'b100;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    // Fractional encodings (101/110/111) occupy a single register, so they
    // decode to LMUL=1. The reserved encoding keeps LMUL=1 so the illegal
    // beat still has a well-defined shape.
    function automatic logic [4:0] lmul_decode(input logic [2:0] vlmul);
        logic [4:0] res;
        case (vlmul)
            VLMUL_M1:   res = {4'd1, 1'b0};
            VLMUL_M2:   res = {4'd2, 1'b0};
            VLMUL_M4:   res = {4'd4, 1'b0};
            VLMUL_M8:   res = {4'd8, 1'b0};
            VLMUL_RSVD: res = {4'd1, 1'b1};
            default:    res = {4'd1, 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lmul_uop_sequencer_if.sv
// Decode-side instruction handshake plus register-read-side micro-op handshake.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master drives instructions and out_ready, slave is the sequencer.
interface lmul_uop_sequencer_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_raA;
    logic [REG_AW-1:0] in_raB;
    logic [REG_AW-1:0] in_rdest;
    logic [2:0]        in_vlmul;
    logic              in_widen;

    logic              out_valid;
    logic              out_ready;
    logic [REG_AW-1:0] out_raA;
    logic [REG_AW-1:0] out_raB;
    logic [REG_AW-1:0] out_rdest;
    logic [CNT_W-1:0]  out_uop_idx;
    logic              out_last;
    logic              out_illegal;

    modport master (
        output in_valid, in_raA, in_raB, in_rdest, in_vlmul, in_widen, out_ready,
        input  in_ready, out_valid, out_raA, out_raB, out_rdest, out_uop_idx,
               out_last, out_illegal
    );

    modport slave (
        input  in_valid, in_raA, in_raB, in_rdest, in_vlmul, in_widen, out_ready,
        output in_ready, out_valid, out_raA, out_raB, out_rdest, out_uop_idx,
               out_last, out_illegal
    );
endinterface

// File: rtl/lmul_uop_sequencer_group_check.sv
// Register-group legality check: decodes vlmul, returns group size N and illegal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: vlmul_i/widen_i/raA_i/raB_i/rdest_i in; grp_n_o (N), illegal_o out. WIDEN_EN honours widen_i.
module lmul_group_check
    import vec_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_LMUL = 8,
    parameter int CNT_W    = 4
) (
    input  logic [2:0]        vlmul_i,
    input  logic              widen_i,
    input  logic [REG_AW-1:0] raA_i,
    input  logic [REG_AW-1:0] raB_i,
    input  logic [REG_AW-1:0] rdest_i,
    output logic [CNT_W:0]    grp_n_o,
    output logic              illegal_o
);

    logic              wide;
    logic [3:0]        lmul;
    logic              dec_ill;
    logic [4:0]        n;
    logic [REG_AW-1:0] lmul_m1;
    logic [REG_AW-1:0] n_m1;

`ifdef WIDEN_EN
    assign wide = widen_i;
`else
    logic unused_widen;
    assign unused_widen = widen_i;
    assign wide         = 1'b0;
`endif

    always_comb begin
        {lmul, dec_ill} = lmul_decode(vlmul_i);
        n               = wide ? ({1'b0, lmul} << 1) : {1'b0, lmul};
        // Group sizes are powers of two, so alignment is a low-bit mask test.
        lmul_m1         = REG_AW'(lmul) - REG_AW'(1);
        n_m1            = REG_AW'(n) - REG_AW'(1);
        illegal_o       = dec_ill
                        | (int'(lmul) > MAX_LMUL)
                        | (wide && (2 * int'(lmul) > MAX_LMUL))
                        | (|(raA_i & lmul_m1))
                        | (|(raB_i & lmul_m1))
                        | (|(rdest_i & n_m1));
        grp_n_o         = (CNT_W+1)'(n);
    end

endmodule

// File: rtl/lmul_uop_sequencer.sv
// Expands one vector ALU instruction into N register-level micro-ops (N=LMUL, 2*LMUL widening).
// Latency: first micro-op registered one cycle after acceptance; back-to-back groups without a bubble.
// Backpressure: in_ready low while a group is in flight; outputs hold while out_ready low; flush aborts.
// Ports: clk, rst (sync, active-high), flush, bus (slave modport). Optional macro: WIDEN_EN.
module lmul_uop_sequencer
    import vec_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_LMUL = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    lmul_uop_sequencer_if.slave bus
);

    seq_state_t        state_q, state_d;
    logic [REG_AW-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
    logic [REG_AW-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
    logic [CNT_W-1:0]  idx_q, idx_d, last_idx_q, last_idx_d;
    logic              last_q, last_d, illegal_q, illegal_d;
    logic [CNT_W-1:0]  nxt_idx, src_off;
    logic [CNT_W:0]    grp_n;
    logic              chk_ill, out_vld, in_rdy, accept, beat;
`ifdef WIDEN_EN
    logic              widen_q, widen_d;
`endif

    lmul_group_check #(
        .REG_AW  (REG_AW),
        .MAX_LMUL(MAX_LMUL),
        .CNT_W   (CNT_W)
    ) u_check (
        .vlmul_i  (bus.in_vlmul),
        .widen_i  (bus.in_widen),
        .raA_i    (bus.in_raA),
        .raB_i    (bus.in_raB),
        .rdest_i  (bus.in_rdest),
        .grp_n_o  (grp_n),
        .illegal_o(chk_ill)
    );

    assign out_vld = (state_q == ISSUE);
    assign beat    = out_vld & bus.out_ready;
    // A new instruction may enter on the final beat of the current group.
    assign in_rdy  = ~flush & ((state_q == IDLE) | (beat & last_q));
    assign accept  = bus.in_valid & in_rdy;

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld;
    assign bus.out_raA     = ra_q;
    assign bus.out_raB     = rb_q;
    assign bus.out_rdest   = rd_q;
    assign bus.out_uop_idx = idx_q;
    assign bus.out_last    = last_q;
    assign bus.out_illegal = illegal_q;

    always_comb begin
        state_d    = state_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        d_base_d   = d_base_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rd_d       = rd_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        last_d     = last_q;
        illegal_d  = illegal_q;
`ifdef WIDEN_EN
        widen_d    = widen_q;
`endif
        nxt_idx    = idx_q + CNT_W'(1);
`ifdef WIDEN_EN
        // Widening sources advance once per pair of destination registers.
        src_off    = widen_q ? (nxt_idx >> 1) : nxt_idx;
`else
        src_off    = nxt_idx;
`endif

        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d    = ISSUE;
            a_base_d   = bus.in_raA;
            b_base_d   = bus.in_raB;
            d_base_d   = bus.in_rdest;
            ra_d       = bus.in_raA;
            rb_d       = bus.in_raB;
            rd_d       = bus.in_rdest;
            idx_d      = '0;
            illegal_d  = chk_ill;
            // Illegal groups collapse to a single beat at index 0.
            last_idx_d = chk_ill ? '0 : CNT_W'(grp_n - (CNT_W+1)'(1));
            last_d     = chk_ill | (grp_n == (CNT_W+1)'(1));
`ifdef WIDEN_EN
            widen_d    = bus.in_widen;
`endif
        end else if (beat) begin
            if (last_q) begin
                state_d = IDLE;
            end else begin
                idx_d  = nxt_idx;
                ra_d   = a_base_q + REG_AW'(src_off);
                rb_d   = b_base_q + REG_AW'(src_off);
                rd_d   = d_base_q + REG_AW'(nxt_idx);
                last_d = (nxt_idx == last_idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_base_q   <= '0;
            b_base_q   <= '0;
            d_base_q   <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            last_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef WIDEN_EN
            widen_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            d_base_q   <= d_base_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rd_q       <= rd_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            last_q     <= last_d;
            illegal_q  <= illegal_d;
`ifdef WIDEN_EN
            widen_q    <= widen_d;
`endif
        end
    end

endmodule

// File: tb/tb_lmul_uop_sequencer.sv
// Self-checking bench for lmul_uop_sequencer: directed scenarios plus random traffic vs a queue model.
// Latency: n/a.
// Backpressure: randomised out_ready and occasional flush.
module tb_lmul_uop_sequencer;

    localparam int REG_AW   = 5;
    localparam int MAX_LMUL = 8;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rd;
        logic [3:0] idx;
        logic       last;
        logic       ill;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    lmul_uop_sequencer_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus();

    lmul_uop_sequencer #(
        .REG_AW  (REG_AW),
        .MAX_LMUL(MAX_LMUL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    bit    acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: expected micro-op list for one accepted instruction.
    task automatic push_group(input logic [2:0] vl, input logic w_in,
                              input int a, input int b, input int d);
        int    lmul, n, off;
        bit    ill, w;
        beat_t bt;
        ill = 0;
        case (vl)
            3'd0:    lmul = 1;
            3'd1:    lmul = 2;
            3'd2:    lmul = 4;
            3'd3:    lmul = 8;
            3'd4:    begin lmul = 1; ill = 1; end
            default: lmul = 1;
        endcase
`ifdef WIDEN_EN
        w = w_in;
`else
        w = 0;
        if (w_in) w = 0;
`endif
        n = w ? 2 * lmul : lmul;
        if (lmul > MAX_LMUL) ill = 1;
        if (w && 2 * lmul > MAX_LMUL) ill = 1;
        if ((a % lmul) != 0 || (b % lmul) != 0 || (d % n) != 0) ill = 1;
        if (ill) begin
            bt = '{ra: 5'(a), rb: 5'(b), rd: 5'(d), idx: 4'd0, last: 1'b1, ill: 1'b1};
            exp_q.push_back(bt);
        end else begin
            for (int i = 0; i < n; i++) begin
                off = w ? i / 2 : i;
                bt = '{ra: 5'((a + off) % 32), rb: 5'((b + off) % 32), rd: 5'((d + i) % 32),
                       idx: 4'(i), last: (i == n - 1), ill: 1'b0};
                exp_q.push_back(bt);
            end
        end
    endtask

    // One cycle: observe just after the inputs settle, update model, advance to next negedge.
    task automatic step();
        beat_t obs;
        bit    exp_rdy;
        #1;
        obs = '{ra: bus.out_raA, rb: bus.out_raB, rd: bus.out_rdest, idx: bus.out_uop_idx,
                last: bus.out_last, ill: bus.out_illegal};
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (bus.out_valid && exp_q.size() != 0) check("uop", 32'(obs), 32'(exp_q[0]));
        if (bus.out_valid && bus.out_ready && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        exp_rdy = !flush && exp_q.size() == 0;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = bus.in_valid && bus.in_ready;
        if (acc) push_group(bus.in_vlmul, bus.in_widen, int'(bus.in_raA), int'(bus.in_raB),
                            int'(bus.in_rdest));
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] vl, input logic w, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d);
        bus.in_valid = 1'b1;
        bus.in_vlmul = vl;
        bus.in_widen = w;
        bus.in_raA   = a;
        bus.in_raB   = b;
        bus.in_rdest = d;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) step();
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    initial begin
        logic [4:0] al_mask;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_vlmul = 3'd0;
        bus.in_widen = 1'b0;
        bus.in_raA   = '0;
        bus.in_raB   = '0;
        bus.in_rdest = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_last_ill_idx", 32'({bus.out_last, bus.out_illegal, bus.out_uop_idx}), 32'd0);
        check("rst_regs", 32'({bus.out_raA, bus.out_raB, bus.out_rdest}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-register group.
        send(3'b000, 1'b0, 5'd2, 5'd3, 5'd4);
        drain();
        // LMUL=4 group at full throughput.
        send(3'b010, 1'b0, 5'd8, 5'd12, 5'd16);
        drain();
        // Same group stalled for three cycles on idx 1.
        send(3'b010, 1'b0, 5'd8, 5'd12, 5'd16);
        step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b1;
        drain();
        // Misaligned destination, then reserved encoding.
        send(3'b001, 1'b0, 5'd2, 5'd4, 5'd3);
        drain();
        send(3'b100, 1'b0, 5'd0, 5'd0, 5'd0);
        drain();
        // Back-to-back: second accepted on the first group's last beat.
        send(3'b010, 1'b0, 5'd8, 5'd12, 5'd16);
        send(3'b000, 1'b0, 5'd2, 5'd3, 5'd4);
        drain();
        // Widening pair (plain LMUL=2 group when widening is not built in).
        send(3'b001, 1'b1, 5'd4, 5'd6, 5'd8);
        drain();
        // Flush at idx 2 of an LMUL=8 group.
        send(3'b011, 1'b0, 5'd0, 5'd8, 5'd16);
        step();
        step();
        check("pre_flush_idx", 32'(bus.out_uop_idx), 32'd2);
        flush = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Random traffic.
        for (int it = 0; it < 600; it++) begin
            al_mask      = 5'h1f << $urandom_range(0, 4);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_vlmul = 3'($urandom_range(0, 7));
            bus.in_widen = 1'($urandom_range(0, 1));
            bus.in_raA   = 5'($urandom_range(0, 31)) & (($urandom_range(0, 3) != 0) ? al_mask : 5'h1f);
            bus.in_raB   = 5'($urandom_range(0, 31)) & (($urandom_range(0, 3) != 0) ? al_mask : 5'h1f);
            bus.in_rdest = 5'($urandom_range(0, 31)) & (($urandom_range(0, 3) != 0) ? al_mask : 5'h1f);
            flush        = ($urandom_range(0, 31) == 0);
            bus.out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
            step();
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
